// File: rtl/mips_run_monitor.sv
// -----------------------------------------------------------------------------
// mips_run_monitor
//
// Run controller / observer that sits beside the MIPS top level, in simulation
// and on the board. It sequences the processor reset, counts the cycles the
// processor runs, and detects program halt. Halt means the PC has stayed
// unchanged for HALT_WINDOW consecutive comparisons. On halt it takes a
// snapshot of NUM_CH display registers (v0, v1, ...) and offers that snapshot
// to a consumer through a valid/ack pair.
//
// Optional feature (build macro WATCHDOG_EN):
//   When defined, a watchdog ends the run after MAX_CYCLES-1 counted cycles if
//   no halt has been seen. The snapshot is still captured and timeout is raised
//   instead of halted. When undefined there is no watchdog logic at all,
//   timeout is tied low and MAX_CYCLES is only sanity-checked.
//
// Parameters
//   NUM_CH        number of display channels captured
//   DATA_W        width of each display channel and of pc
//   RESET_CYCLES  cycles cpu_reset stays high after Reset releases (>= 1)
//   HALT_WINDOW   consecutive equal-PC comparisons that declare halt (>= 2)
//   CNT_W         cycle counter width
//   MAX_CYCLES    watchdog limit (WATCHDOG_EN builds only)
//
// Ports
//   Clk           in   clock, all logic on the rising edge
//   Reset         in   synchronous, active-high
//   pc            in   processor PC
//   display       in   channel k at [k*DATA_W +: DATA_W]
//   result_ack    in   consumer accepts result (only looked at in DONE)
//   cpu_reset     out  registered reset to the processor
//   running       out  high while in RUN
//   halted        out  halt detected, sticky until Reset
//   timeout       out  watchdog expired, sticky until Reset
//   cycle_count   out  RUN cycles elapsed, saturating
//   result        out  captured display snapshot
//   result_valid  out  snapshot available
//
// Result handshake: result_valid rises on the edge that captures the
// snapshot. It then stays high, with result stable, until an edge samples
// result_ack=1 while valid is up. On that edge result_valid falls and never
// rises again until the next Reset. result_ack at any other time has no effect.
// -----------------------------------------------------------------------------
module mips_run_monitor #(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 32,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_WINDOW  = 8,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 1000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        pc,
    input  logic [NUM_CH*DATA_W-1:0] display,
    input  logic                     result_ack,
    output logic                     cpu_reset,
    output logic                     running,
    output logic                     halted,
    output logic                     timeout,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [NUM_CH*DATA_W-1:0] result,
    output logic                     result_valid
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
            $error("mips_run_monitor: RESET_CYCLES must be at least 1");
        end
        if (HALT_WINDOW < 2) begin : g_bad_halt_window
            $error("mips_run_monitor: HALT_WINDOW must be at least 2");
        end
        if (MAX_CYCLES < 1) begin : g_bad_max_cycles
            $error("mips_run_monitor: MAX_CYCLES must be at least 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Local sizing
    // -------------------------------------------------------------------------
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STAB_W = $clog2(HALT_WINDOW + 1);

    // Last value of the hold counter before leaving HOLD. The counter starts at
    // 0 on the first edge after Reset releases, so cpu_reset is high for
    // exactly RESET_CYCLES cycles.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    // Stable-count value that, with one more equal compare, reaches HALT_WINDOW.
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(HALT_WINDOW - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STAB_W-1:0]  stable_cnt;
    logic [DATA_W-1:0]  prev_pc;
    logic               prev_valid;

    // -------------------------------------------------------------------------
    // RUN-cycle decisions
    // -------------------------------------------------------------------------
    logic pc_equal;
    logic halt_now;
    logic wd_now;
    logic cnt_max;

    // The first RUN cycle has no previous PC to compare against.
    assign pc_equal = prev_valid && (pc == prev_pc);

    // This compare is the HALT_WINDOW-th equal compare in a row.
    assign halt_now = pc_equal && (stable_cnt == STAB_LAST);

    assign cnt_max  = &cycle_count;

`ifdef WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    // A halt seen in the same cycle takes priority over the watchdog.
    assign wd_now = (cycle_count == WD_LAST) && !halt_now;
`else
    assign wd_now = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Main sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_HOLD;
            hold_cnt     <= '0;
            stable_cnt   <= '0;
            prev_pc      <= '0;
            prev_valid   <= 1'b0;
            cpu_reset    <= 1'b1;
            running      <= 1'b0;
            halted       <= 1'b0;
            cycle_count  <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // The processor leaves reset on the same edge that
                        // running rises.
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    prev_pc    <= pc;
                    prev_valid <= 1'b1;

                    if (pc_equal) begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end else begin
                        stable_cnt <= '0;
                    end

                    // The watchdog cycle is not counted, so the count shows
                    // MAX_CYCLES-1 when the watchdog fires.
                    if (!wd_now && !cnt_max) begin
                        cycle_count <= cycle_count + 1'b1;
                    end

                    if (halt_now || wd_now) begin
                        // Sample display in the same cycle the decision is
                        // made; this snapshot is never updated afterwards.
                        result       <= display;
                        result_valid <= 1'b1;
                        halted       <= halt_now;
                        running      <= 1'b0;
                        state        <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    // Wait for Reset. The processor keeps spinning in its
                    // halt loop with cpu_reset low.
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog flag
    // -------------------------------------------------------------------------
`ifdef WATCHDOG_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            timeout <= 1'b0;
        end else if ((state == ST_RUN) && wd_now) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_mips_run_monitor
//
// Self-checking bench for mips_run_monitor.
//
// The reference model is history based. It counts edges since Reset to decide
// the hold phase. It keeps every PC sampled during RUN, and declares halt when
// the last HALT_WINDOW+1 samples are all equal.
//
// A second instance with a 4-bit cycle counter checks that the counter
// saturates instead of wrapping.
// -----------------------------------------------------------------------------
module tb_mips_run_monitor;

    localparam int NUM_CH       = 2;
    localparam int DATA_W       = 32;
    localparam int RESET_CYCLES = 4;
    localparam int HALT_WINDOW  = 8;
    localparam int CNT_W        = 32;
    localparam int MAX_CYCLES   = 50;
    localparam int SAT_W        = 4;
    localparam int DW           = NUM_CH * DATA_W;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst     = 1'b1;
    logic [DATA_W-1:0] pc      = '0;
    logic [DW-1:0]     display = '0;
    logic              ack     = 1'b0;

    logic              cpu_reset, running, halted, timeout, result_valid;
    logic [CNT_W-1:0]  cycle_count;
    logic [DW-1:0]     result;

    logic              s_cpu_reset, s_running, s_halted, s_timeout, s_result_valid;
    logic [SAT_W-1:0]  s_cycle_count;
    logic [DW-1:0]     s_result;

    mips_run_monitor #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RESET_CYCLES(RESET_CYCLES),
        .HALT_WINDOW(HALT_WINDOW), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .Clk(clk), .Reset(rst), .pc(pc), .display(display), .result_ack(ack),
        .cpu_reset(cpu_reset), .running(running), .halted(halted), .timeout(timeout),
        .cycle_count(cycle_count), .result(result), .result_valid(result_valid)
    );

    mips_run_monitor #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RESET_CYCLES(RESET_CYCLES),
        .HALT_WINDOW(HALT_WINDOW), .CNT_W(SAT_W), .MAX_CYCLES(15)
    ) dut_sat (
        .Clk(clk), .Reset(rst), .pc(pc), .display(display), .result_ack(ack),
        .cpu_reset(s_cpu_reset), .running(s_running), .halted(s_halted), .timeout(s_timeout),
        .cycle_count(s_cycle_count), .result(s_result), .result_valid(s_result_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------------------------------------------------------- reference model
    int                m_hold;
    logic [DATA_W-1:0] m_pcs[$];
    bit                m_done, m_halted, m_timeout, m_valid;
    logic [DW-1:0]     m_result;
    int                m_count;

    task automatic model_edge(input bit r, input logic [DATA_W-1:0] p,
                              input logic [DW-1:0] d, input bit a);
        bit halt;
        int k;
        if (r) begin
            m_hold = 0; m_pcs.delete(); m_done = 0; m_halted = 0;
            m_timeout = 0; m_valid = 0; m_result = '0; m_count = 0;
        end else if (m_hold < RESET_CYCLES) begin
            m_hold++;
        end else if (!m_done) begin
            m_pcs.push_back(p);
            k = m_pcs.size() - 1;
            halt = 0;
            if (k >= HALT_WINDOW) begin
                halt = 1;
                for (int i = k - HALT_WINDOW; i < k; i++)
                    if (m_pcs[i] != p) halt = 0;
            end
            if (halt) begin
                m_done = 1; m_halted = 1; m_valid = 1; m_result = d; m_count++;
            end
`ifdef WATCHDOG_EN
            else if (m_count == MAX_CYCLES - 1) begin
                m_done = 1; m_timeout = 1; m_valid = 1; m_result = d;
            end
`endif
            else begin
                m_count++;
            end
        end else if (m_valid && a) begin
            m_valid = 0;
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    // One clock: apply inputs, let the edge happen, sample 1 ns later.
    task automatic step(input bit r, input logic [DATA_W-1:0] p,
                        input logic [DW-1:0] d, input bit a);
        rst = r; pc = p; display = d; ack = a;
        @(posedge clk);
        #1;
        model_edge(r, p, d, a);
    endtask

    function automatic logic [DW-1:0] rand_disp();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b0);
        for (int i = 0; i < RESET_CYCLES; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        step(1'b1, 32'h1234, rand_disp(), 1'b1);
        n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_cmp++; if (cycle_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    endtask

    task automatic test_hold();
        for (int i = 1; i <= RESET_CYCLES; i++) begin
            step(1'b0, DATA_W'($urandom()), rand_disp(), 1'b0);
            n_cmp++; if (cpu_reset !== (i < RESET_CYCLES)) begin n_bad++; $display("FAIL hold_cpu_reset[%0d]: got %b want %b", i, cpu_reset, (i < RESET_CYCLES)); end
            n_cmp++; if (running !== (i == RESET_CYCLES)) begin n_bad++; $display("FAIL hold_running[%0d]: got %b want %b", i, running, (i == RESET_CYCLES)); end
        end
        n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL run_first_count: got %0d want 0", cycle_count); end
        step(1'b0, 32'h0, rand_disp(), 1'b0);
        n_cmp++; if (cycle_count !== 32'd1) begin n_bad++; $display("FAIL run_second_count: got %0d want 1", cycle_count); end
    endtask

    logic [DW-1:0] snap;
    logic [CNT_W-1:0] frozen;

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, DATA_W'(i * 4), rand_disp(), 1'b0);
        for (int j = 0; j <= HALT_WINDOW; j++) begin
            step(1'b0, 32'h40, (j == HALT_WINDOW) ? {32'h9, 32'h5} : rand_disp(), 1'b0);
            if (j < HALT_WINDOW) begin
                n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early[%0d]: got %b want 0", j, halted); end
            end
        end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_halted: got %b want 1", halted); end
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL halt_valid: got %b want 1", result_valid); end
        n_cmp++; if (result !== {32'h9, 32'h5}) begin n_bad++; $display("FAIL halt_result: got %h want %h", result, {32'h9, 32'h5}); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL halt_running: got %b want 0", running); end
        n_cmp++; if (cycle_count !== CNT_W'(m_count)) begin n_bad++; $display("FAIL halt_count: got %0d want %0d", cycle_count, m_count); end
        snap = {32'h9, 32'h5};
        frozen = CNT_W'(m_count);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, DATA_W'($urandom()), rand_disp(), 1'b0);
            n_cmp++; if (cycle_count !== frozen) begin n_bad++; $display("FAIL halt_frozen[%0d]: got %0d want %0d", i, cycle_count, frozen); end
        end
    endtask

    task automatic test_ack();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h40, rand_disp(), 1'b0);
            n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL ack_wait_valid[%0d]: got %b want 1", i, result_valid); end
            n_cmp++; if (result !== snap) begin n_bad++; $display("FAIL ack_wait_result[%0d]: got %h want %h", i, result, snap); end
        end
        step(1'b0, 32'h40, rand_disp(), 1'b1);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL ack_drop: got %b want 0", result_valid); end
        n_cmp++; if (result !== snap) begin n_bad++; $display("FAIL ack_result: got %h want %h", result, snap); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, DATA_W'($urandom()), rand_disp(), 1'($urandom_range(0, 1)));
            n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL ack_late_valid[%0d]: got %b want 0", i, result_valid); end
            n_cmp++; if (result !== snap) begin n_bad++; $display("FAIL ack_late_result[%0d]: got %h want %h", i, result, snap); end
            n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL ack_late_halted[%0d]: got %b want 1", i, halted); end
        end
    endtask

    task automatic test_no_halt();
        logic [DATA_W-1:0] v, prev;
        do_reset();
        prev = DATA_W'($urandom());
        for (int r = 0; r < 4; r++) begin
            v = DATA_W'($urandom());
            if (v == prev) v = v ^ 32'h1;
            prev = v;
            for (int j = 0; j < HALT_WINDOW; j++) begin
                step(1'b0, v, rand_disp(), 1'b0);
                n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL nohalt_halted[%0d.%0d]: got %b want 0", r, j, halted); end
                n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL nohalt_running[%0d.%0d]: got %b want 1", r, j, running); end
            end
        end
`ifndef WATCHDOG_EN
        n_cmp++; if (s_cycle_count !== 4'hF) begin n_bad++; $display("FAIL sat_count: got %0d want 15", s_cycle_count); end
`endif
        // A full window after the near misses must still halt on time.
        v = prev ^ 32'h8000_0000;
        for (int j = 0; j <= HALT_WINDOW; j++) begin
            step(1'b0, v, rand_disp(), 1'b0);
            n_cmp++; if (halted !== (j == HALT_WINDOW)) begin n_bad++; $display("FAIL nohalt_final[%0d]: got %b want %b", j, halted, (j == HALT_WINDOW)); end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'b0, DATA_W'(i * 4 + 4), rand_disp(), 1'b0);
            n_cmp++; if (timeout !== m_timeout) begin n_bad++; $display("FAIL wd_timeout[%0d]: got %b want %b", i, timeout, m_timeout); end
            n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL wd_halted[%0d]: got %b want 0", i, halted); end
        end
`ifdef WATCHDOG_EN
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL wd_final_timeout: got %b want 1", timeout); end
        n_cmp++; if (cycle_count !== CNT_W'(MAX_CYCLES - 1)) begin n_bad++; $display("FAIL wd_final_count: got %0d want %0d", cycle_count, MAX_CYCLES - 1); end
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL wd_final_valid: got %b want 1", result_valid); end
`else
        n_cmp++; if (cycle_count !== 32'd60) begin n_bad++; $display("FAIL wd_off_count: got %0d want 60", cycle_count); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL wd_off_running: got %b want 1", running); end
`endif
    endtask

    task automatic test_halt_vs_watchdog();
        do_reset();
        for (int i = 0; i < MAX_CYCLES; i++) begin
            step(1'b0, (i <= MAX_CYCLES - 2 - HALT_WINDOW) ? DATA_W'(i * 4) : 32'h1000, rand_disp(), 1'b0);
            n_cmp++; if (halted !== m_halted) begin n_bad++; $display("FAIL tie_halted[%0d]: got %b want %b", i, halted, m_halted); end
            n_cmp++; if (timeout !== m_timeout) begin n_bad++; $display("FAIL tie_timeout[%0d]: got %b want %b", i, timeout, m_timeout); end
        end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL tie_final_halted: got %b want 1", halted); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL tie_final_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b0, DATA_W'(i * 4), rand_disp(), 1'b0);
        step(1'b1, 32'h0, rand_disp(), 1'b0);
        n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL mid_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mid_running: got %b want 0", running); end
        n_cmp++; if (cycle_count !== '0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", cycle_count); end
        n_cmp++; if (halted !== 1'b0 || timeout !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
            n_bad++; $display("FAIL mid_flags: got h%b t%b v%b r%h want all 0", halted, timeout, result_valid, result);
        end
        for (int i = 1; i <= RESET_CYCLES; i++) begin
            step(1'b0, 32'h0, rand_disp(), 1'b0);
            n_cmp++; if (cpu_reset !== (i < RESET_CYCLES)) begin n_bad++; $display("FAIL mid_hold_cpu_reset[%0d]: got %b want %b", i, cpu_reset, (i < RESET_CYCLES)); end
            n_cmp++; if (running !== (i == RESET_CYCLES)) begin n_bad++; $display("FAIL mid_hold_running[%0d]: got %b want %b", i, running, (i == RESET_CYCLES)); end
        end
        step(1'b0, 32'h4, rand_disp(), 1'b0);
        n_cmp++; if (cycle_count !== 32'd1) begin n_bad++; $display("FAIL mid_restart_count: got %0d want 1", cycle_count); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] p;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            p = DATA_W'($urandom());
            for (int c = 0; c < 70; c++) begin
                if ($urandom_range(0, 99) >= 80) p = DATA_W'($urandom_range(0, 3)) ^ p ^ 32'h10;
                step(1'b0, p, rand_disp(), ($urandom_range(0, 3) == 0));
                n_cmp++; if (cpu_reset !== (m_hold < RESET_CYCLES)) begin n_bad++; $display("FAIL rnd_cpu_reset[%0d.%0d]: got %b want %b", r, c, cpu_reset, (m_hold < RESET_CYCLES)); end
                n_cmp++; if (running !== (m_hold >= RESET_CYCLES && !m_done)) begin n_bad++; $display("FAIL rnd_running[%0d.%0d]: got %b", r, c, running); end
                n_cmp++; if (halted !== m_halted) begin n_bad++; $display("FAIL rnd_halted[%0d.%0d]: got %b want %b", r, c, halted, m_halted); end
                n_cmp++; if (timeout !== m_timeout) begin n_bad++; $display("FAIL rnd_timeout[%0d.%0d]: got %b want %b", r, c, timeout, m_timeout); end
                n_cmp++; if (cycle_count !== CNT_W'(m_count)) begin n_bad++; $display("FAIL rnd_count[%0d.%0d]: got %0d want %0d", r, c, cycle_count, m_count); end
                n_cmp++; if (result_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d.%0d]: got %b want %b", r, c, result_valid, m_valid); end
                n_cmp++; if (result !== m_result) begin n_bad++; $display("FAIL rnd_result[%0d.%0d]: got %h want %h", r, c, result, m_result); end
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence + report
    initial begin
        test_reset();
        test_hold();
        test_halt();
        test_ack();
        test_no_halt();
        test_watchdog();
        test_halt_vs_watchdog();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
